// File: rtl/lfsr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : lfsr_pkg                                                 |
// | Brief   : Shared defaults and helpers for the Fibonacci LFSR.      |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package lfsr_pkg;

    // PRBS7: x^7 + x^6 + 1
    localparam int unsigned DEFAULT_WIDTH = 7;
    localparam logic [6:0]  DEFAULT_TAPS  = 7'b1100000;

    // Maximal-length period of a WIDTH-bit LFSR
    function automatic int unsigned lfsr_period(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_period_ctr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : lfsr_period_ctr                                          |
// | Brief   : Counts shifts of one LFSR run and owns the valid flag.   |
// |           active is high for exactly one full period per start.    |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module lfsr_period_ctr
    import lfsr_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic step,
    output logic active
);

    // Last count value at which active is still high (period - 1 shifts done)
    localparam logic [WIDTH-1:0] C_LAST = WIDTH'(lfsr_period(WIDTH) - 32'd1);

    // cnt reaches at most 2^WIDTH-1, so WIDTH bits never wrap within a run
    logic [WIDTH-1:0] r_cnt;
    logic             r_active;

    // Reset beats start; start beats stepping; hold when inactive
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (step && r_active) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == C_LAST) begin
                r_active <= 1'b0;
            end
        end
    end

    assign active = r_active;

endmodule
`default_nettype wire

// File: rtl/lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : lfsr                                                     |
// | Brief   : Fibonacci LFSR with seed load and one-period valid       |
// |           window. Optional macro LFSR_ZERO_GUARD_EN replaces a     |
// |           zero seed with all-ones to avoid lock-up.                |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module lfsr
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic             q,
    output logic             valid_out
);

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_load_val;
    logic             w_fb;
    logic             w_active;

`ifdef LFSR_ZERO_GUARD_EN
    // An all-zero state never leaves zero; substitute all-ones
    assign w_load_val = (seed == '0) ? '1 : seed;
`else
    assign w_load_val = seed;
`endif

    assign w_fb = ^(r_state & TAPS);

    // State register: reset > load > shift while the run is active
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= '0;
        end else if (load) begin
            r_state <= w_load_val;
        end else if (w_active) begin
            r_state <= {r_state[WIDTH-2:0], w_fb};
        end
    end

    lfsr_period_ctr #(
        .WIDTH (WIDTH)
    ) u_period_ctr (
        .clk    (clk),
        .reset  (reset),
        .start  (load),
        .step   (~load),
        .active (w_active)
    );

    assign valid_out = w_active;
    assign q         = w_active & r_state[WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_lfsr                                                  |
// | Brief   : Scoreboard bench for lfsr (PRBS7 default).               |
// |           Honours LFSR_ZERO_GUARD_EN for the zero-seed case.       |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module tb_lfsr;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [6:0] seed = '0;
    logic       q;
    logic       valid_out;

    int errors = 0;
    int checks = 0;

    logic sb[$];     // expected q for each upcoming valid cycle
    int   vcount;    // valid cycles seen since last load
    int   ones;      // ones seen on q since last load

    lfsr dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .seed      (seed),
        .q         (q),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // x^7 + x^6 + 1, written out bit by bit
    function automatic logic [6:0] nxt(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

    // Issue: restart the expected stream for a freshly loaded seed
    task automatic push_run(input logic [6:0] s0);
        logic [6:0] s;
        s = s0;
        sb.delete();
        vcount = 0;
        ones   = 0;
        for (int i = 0; i < 127; i++) begin
            sb.push_back(s[6]);
            s = nxt(s);
        end
    endtask

    // Drive point: just after the monitor's sampling edge
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (valid_out && n < 300) begin
            tick();
            n++;
        end
        if (valid_out) check({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    // Monitor: pop and compare on every valid output cycle
    always @(negedge clk) begin
        if (valid_out) begin
            vcount++;
            if (q === 1'b1) ones++;
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                check("q_stream", {31'd0, q}, {31'd0, sb.pop_front()});
            end
        end else if (!reset) begin
            check("q_idle", {31'd0, q}, 32'd0);
        end
    end

    initial begin
        vcount = 0;
        ones   = 0;

        // Reset held two cycles
        tick(); tick();
        check("rst_q", {31'd0, q}, 32'd0);
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_state", {25'd0, dut.r_state}, 32'd0);

        // Load in the very first cycle after reset release
        reset = 1'b0;
        load  = 1'b1;
        seed  = 7'b1010101;
        push_run(seed);
        tick();
        load = 1'b0;
        check("load_valid", {31'd0, valid_out}, 32'd1);
        check("q0", {31'd0, q}, 32'd1);
        tick();
        check("q1", {31'd0, q}, 32'd0);
        tick();
        check("q2", {31'd0, q}, 32'd1);
        check("state_2shift", {25'd0, dut.r_state}, 32'h57);
        wait_idle("run1");
        check("run1_len", vcount, 127);
        check("run1_ones", ones, 64);
        check("run1_state", {25'd0, dut.r_state}, 32'h55);
        check("run1_sb_empty", sb.size(), 0);
        tick(); tick();
        check("hold_state", {25'd0, dut.r_state}, 32'h55);
        check("hold_valid", {31'd0, valid_out}, 32'd0);

        // Mid-run restart after 40 cycles
        load = 1'b1;
        seed = 7'b0000001;
        push_run(seed);
        tick();
        load = 1'b0;
        repeat (39) tick();
        load = 1'b1;
        seed = 7'b1110000;
        push_run(seed);
        tick();
        load = 1'b0;
        check("restart_q0", {31'd0, q}, 32'd1);
        wait_idle("run2");
        check("run2_len", vcount, 127);
        check("run2_state", {25'd0, dut.r_state}, 32'h70);
        check("run2_sb_empty", sb.size(), 0);

        // Load held high three cycles: sequence starts after it falls
        seed = 7'b0110011;
        load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_run(seed);
            tick();
        end
        load = 1'b0;
        check("hold_load_state", {25'd0, dut.r_state}, 32'h33);
        wait_idle("run3");
        check("run3_len", vcount, 127);
        check("run3_ones", ones, 64);

        // Reset and load together in the middle of a run
        load = 1'b1;
        seed = 7'b1111111;
        push_run(seed);
        tick();
        load = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        load  = 1'b1;
        sb.delete();
        tick();
        check("rl_valid", {31'd0, valid_out}, 32'd0);
        check("rl_state", {25'd0, dut.r_state}, 32'd0);
        check("rl_q", {31'd0, q}, 32'd0);
        reset = 1'b0;
        load  = 1'b0;
        tick();

        // Zero seed
        seed = 7'd0;
        load = 1'b1;
`ifdef LFSR_ZERO_GUARD_EN
        push_run(7'h7f);
`else
        push_run(7'h00);
`endif
        tick();
        load = 1'b0;
`ifdef LFSR_ZERO_GUARD_EN
        check("zero_q0", {31'd0, q}, 32'd1);
`else
        check("zero_q0", {31'd0, q}, 32'd0);
`endif
        wait_idle("run_zero");
        check("zero_len", vcount, 127);
`ifdef LFSR_ZERO_GUARD_EN
        check("zero_ones", ones, 64);
`else
        check("zero_ones", ones, 0);
`endif
        check("zero_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
